kmean_mul_arbiter: RTL

- Round-robin arbiter and sequencer that shares one pipelined 7x11 multiplier (unsigned a, signed b, P_WIDTH-bit truncated product) between NUM_REQ requesters in the kmeans distance datapath.
- Registers the granted operands into the multiplier and carries the requester ID alongside in a tag pipeline matching the multiplier latency.
- Captures each product into an in-order response FIFO; a credit check guarantees the FIFO never overflows while rsp_ready is low.

---
 rtl/kmean_mul_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/kmean_mul_arbiter.sv
// Round-robin arbiter that shares one pipelined multiplier between NUM_REQ requesters.
// Products are returned in grant order through a credit-protected response FIFO.
module kmean_mul_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned A_WIDTH     = 7,
  parameter int unsigned B_WIDTH     = 11,
  parameter int unsigned P_WIDTH     = 11,
  parameter int unsigned MUL_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic [A_WIDTH-1:0]         mul_a,
  output logic [B_WIDTH-1:0]         mul_b,
  input  logic [P_WIDTH-1:0]         mul_p,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [P_WIDTH-1:0]         rsp_p,
  output logic [ID_W-1:0]            rsp_id,
  output logic                       idle
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = $clog2(FIFO_DEPTH + MUL_LATENCY + 2);

  logic [A_WIDTH-1:0] req_a_arr [NUM_REQ];
  logic [B_WIDTH-1:0] req_b_arr [NUM_REQ];

  logic [ID_W-1:0]    last;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    scan_id;
  logic               gnt_hit;
  logic               grant_ok;

  // Stage 0 is the issue register; stages 1..MUL_LATENCY track the multiplier.
  logic [MUL_LATENCY:0] pipe_vld;
  logic [ID_W-1:0]      pipe_id [MUL_LATENCY+1];

  logic [P_WIDTH-1:0] fifo_p  [FIFO_DEPTH];
  logic [ID_W-1:0]    fifo_id [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               fifo_full;
  logic               push;
  logic               pop;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_a_arr[g] = req_a[g*A_WIDTH +: A_WIDTH];
    assign req_b_arr[g] = req_b[g*B_WIDTH +: B_WIDTH];
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Same-cycle pops are deliberately not credited, keeping the credit path short.
  assign grant_ok = (SUM_W'($countones(pipe_vld)) + SUM_W'(fifo_cnt)) < SUM_W'(FIFO_DEPTH);

  // Round-robin scan starting one past the last granted requester.
  always_comb begin
    gnt_hit   = 1'b0;
    gnt_id    = '0;
    scan_id   = '0;
    req_ready = '0;
    if (grant_ok && !ap_rst) begin
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
        scan_id = ID_W'((32'(last) + off) % NUM_REQ);
        if (!gnt_hit && req_valid[scan_id]) begin
          gnt_hit = 1'b1;
          gnt_id  = scan_id;
        end
      end
    end
    if (gnt_hit) begin
      req_ready = NUM_REQ'(1) << gnt_id;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      last <= ID_W'(NUM_REQ - 1);
    end else if (gnt_hit) begin
      last <= gnt_id;
    end
  end

  // Issue register and tag pipeline; operands hold when nothing is granted.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      pipe_vld <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      for (int unsigned i = 0; i <= MUL_LATENCY; i++) begin
        pipe_id[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= gnt_hit;
      if (gnt_hit) begin
        pipe_id[0] <= gnt_id;
        mul_a      <= req_a_arr[gnt_id];
        mul_b      <= req_b_arr[gnt_id];
      end
      for (int unsigned i = 1; i <= MUL_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  assign push      = pipe_vld[MUL_LATENCY];
  assign pop       = rsp_valid & rsp_ready;
  assign fifo_full = (fifo_cnt == CNT_W'(FIFO_DEPTH));

  // In-order response FIFO; storage is cleared so the head reads zero after reset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_p[i]  <= '0;
        fifo_id[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_p[wr_ptr]  <= mul_p;
        fifo_id[wr_ptr] <= pipe_id[MUL_LATENCY];
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CNT_W'(1);
      end else if (!push && pop) begin
        fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
    end
  end

  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_p     = fifo_p[rd_ptr];
  assign rsp_id    = fifo_id[rd_ptr];
  assign idle      = (pipe_vld == '0) && (fifo_cnt == '0);

  // The credit rule must make an unpopped push into a full FIFO unreachable.
  a_fifo_overflow: assert property (@(posedge ap_clk) disable iff (ap_rst)
    !(push && fifo_full && !pop));

endmodule
